// File: rtl/bsg_mcl_fifo_mem_responder.sv
// Host-side responder for the manycore request FIFO: emulated byte-maskable word RAM
// serving stores silently and returning one response per load on the response FIFO.
module bsg_mcl_fifo_mem_responder #(
  parameter int unsigned mem_els_p       = 1024,
  parameter int unsigned load_id_width_p = 11,
  parameter logic [7:0]  data_pkt_type_p = 8'h01
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          req_v_i,
  input  logic [127:0]  req_data_i,
  output logic          req_rdy_o,
  output logic          rsp_v_o,
  output logic [127:0]  rsp_data_o,
  input  logic          rsp_rdy_i,
  output logic          oob_err_o,
  output logic [31:0]   load_count_o,
  output logic [31:0]   store_count_o
);

  localparam int unsigned addr_w_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

  typedef struct packed {
    logic [15:0] pad;
    logic [31:0] addr;
    logic [7:0]  op;
    logic [7:0]  op_ex;
    logic [31:0] payload;
    logic [7:0]  src_y;
    logic [7:0]  src_x;
    logic [7:0]  y;
    logic [7:0]  x;
  } req_s;

  typedef struct packed {
    logic [39:0] zero;
    logic [7:0]  pkt_type;
    logic [31:0] data;
    logic [31:0] load_id;
    logic [7:0]  y;
    logic [7:0]  x;
  } rsp_s;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  req_s                       req;
  state_e                     state_q;
  rsp_s                       rsp_q;
  logic                       rsp_v_q;
  logic                       oob_q;
  logic [31:0]                load_count_q, load_count_d;
  logic [31:0]                store_count_q, store_count_d;
  logic [load_id_width_p-1:0] load_id_q;
  logic [7:0]                 src_x_q, src_y_q;
  logic                       load_oob_q;
  logic [31:0]                ram_rdata_q;
  logic [31:0]                mem_r [mem_els_p];

  logic                       req_fire;
  logic                       is_load;
  logic                       in_range;
  logic [addr_w_lp-1:0]       idx;
  logic                       unused_req;

  assign req        = req_data_i;
  assign req_rdy_o  = (state_q == IDLE);
  assign req_fire   = req_v_i & req_rdy_o;
  assign is_load    = (req.op == 8'h00);
  assign in_range   = (req.addr < 32'(mem_els_p));
  assign idx        = req.addr[addr_w_lp-1:0];
  assign unused_req = ^{req.pad, req.op_ex[7:4], req.payload[31:load_id_width_p], req.y, req.x};

  assign load_count_d  = load_count_q + 32'd1;
  assign store_count_d = store_count_q + 32'd1;

  // NOTE: the RAM has no reset so it maps onto block memory and keeps its contents
  // across reset_n_i; only the control state below is reset.
  always_ff @(posedge clk_i) begin
    if (req_fire && !is_load && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req.op_ex[b]) mem_r[idx][8*b +: 8] <= req.payload[8*b +: 8];
      end
    end
    if (req_fire && is_load) ram_rdata_q <= mem_r[idx];
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      rsp_q         <= '0;
      rsp_v_q       <= 1'b0;
      oob_q         <= 1'b0;
      load_count_q  <= '0;
      store_count_q <= '0;
      load_id_q     <= '0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      load_oob_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            if (is_load) begin
              load_count_q <= load_count_d;
              load_id_q    <= req.payload[load_id_width_p-1:0];
              src_x_q      <= req.src_x;
              src_y_q      <= req.src_y;
              load_oob_q   <= !in_range;
              state_q      <= READ;
            end else begin
              store_count_q <= store_count_d;
            end
            if (!in_range) oob_q <= 1'b1;
          end
        end
        READ: begin
          // Out-of-range loads still read a (harmless) aliased word; the data is zeroed here.
          rsp_q <= '{zero:     '0,
                     pkt_type: data_pkt_type_p,
                     data:     load_oob_q ? 32'h0 : ram_rdata_q,
                     load_id:  32'(load_id_q),
                     y:        src_y_q,
                     x:        src_x_q};
          rsp_v_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_rdy_i) begin
            rsp_v_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_v_o       = rsp_v_q;
  assign rsp_data_o    = rsp_q;
  assign oob_err_o     = oob_q;
  assign load_count_o  = load_count_q;
  assign store_count_o = store_count_q;

endmodule

// File: tb/tb_bsg_mcl_fifo_mem_responder.sv
// Self-checking bench: directed scenarios plus random load/store traffic compared
// against an associative-array memory model with plain counters.
module tb_bsg_mcl_fifo_mem_responder;

  localparam int unsigned MEM_ELS = 1024;
  localparam int unsigned ID_W    = 11;
  localparam logic [7:0]  PKT     = 8'h01;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          req_v_i;
  logic [127:0]  req_data_i;
  logic          req_rdy_o;
  logic          rsp_v_o;
  logic [127:0]  rsp_data_o;
  logic          rsp_rdy_i;
  logic          oob_err_o;
  logic [31:0]   load_count_o;
  logic [31:0]   store_count_o;

  bsg_mcl_fifo_mem_responder #(
    .mem_els_p       (MEM_ELS),
    .load_id_width_p (ID_W),
    .data_pkt_type_p (PKT)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req_v_i       (req_v_i),
    .req_data_i    (req_data_i),
    .req_rdy_o     (req_rdy_o),
    .rsp_v_o       (rsp_v_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_rdy_i     (rsp_rdy_i),
    .oob_err_o     (oob_err_o),
    .load_count_o  (load_count_o),
    .store_count_o (store_count_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned rsp_seen = 0;

  // Reference model: word store keyed by address, plus plain counters.
  logic [31:0] mem_m [int unsigned];
  int unsigned loads_m = 0;
  int unsigned stores_m = 0;
  int unsigned rsp_m = 0;
  logic        oob_m = 1'b0;

  always @(posedge clk_i) if (reset_n_i && rsp_v_o && rsp_rdy_i) rsp_seen++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input logic [31:0] addr, input logic [7:0] op,
                                          input logic [7:0] mask, input logic [31:0] payload,
                                          input logic [7:0] sy, input logic [7:0] sx);
    logic [15:0] junk;
    junk = 16'($urandom);
    return {junk, addr, op, mask, payload, sy, sx, 8'($urandom), 8'($urandom)};
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] mask);
    logic [31:0] w;
    stores_m++;
    if (addr < MEM_ELS) begin
      w = mem_m.exists(addr) ? mem_m[addr] : 32'h0;
      for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
      mem_m[addr] = w;
    end else begin
      oob_m = 1'b1;
    end
  endfunction

  // Entered and left at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] req);
    int n;
    n = 0;
    req_v_i    = 1'b1;
    req_data_i = req;
    while (!req_rdy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_rdy_o) check("accept_timeout", 1'b0, 1'b1);
    @(negedge clk_i);
    req_v_i = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    send(mk_req(addr, 8'($urandom_range(1, 255)), {4'($urandom), mask}, data,
                8'($urandom), 8'($urandom)));
    model_store(addr, data, mask);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [ID_W-1:0] id,
                         input logic [7:0] sx, input logic [7:0] sy, input int stall);
    logic [31:0]  payload;
    logic [31:0]  exp_data;
    logic [127:0] exp_rsp;
    int           n;
    payload           = $urandom;
    payload[ID_W-1:0] = id;
    exp_data          = 32'h0;
    if (addr < MEM_ELS) exp_data = mem_m[addr];
    exp_rsp = {40'h0, PKT, exp_data, 32'(id), sy, sx};
    send(mk_req(addr, 8'h00, 8'($urandom), payload, sy, sx));
    loads_m++;
    rsp_m++;
    if (addr >= MEM_ELS) oob_m = 1'b1;
    // One cycle after the handshake the read is in flight; the response shows up the cycle after.
    check("rsp_v_early", rsp_v_o, 1'b0);
    check("rdy_busy_read", req_rdy_o, 1'b0);
    @(negedge clk_i);
    check("rsp_v_latency", rsp_v_o, 1'b1);
    n = 0;
    while (!rsp_v_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("rsp_data", rsp_data_o, exp_rsp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      check("hold_v", rsp_v_o, 1'b1);
      check("hold_data", rsp_data_o, exp_rsp);
      check("hold_rdy", req_rdy_o, 1'b0);
    end
    rsp_rdy_i = 1'b1;
    @(negedge clk_i);
    rsp_rdy_i = 1'b0;
    check("consume_v", rsp_v_o, 1'b0);
    check("consume_rdy", req_rdy_o, 1'b1);
    check("load_count", load_count_o, loads_m);
    check("oob_err", oob_err_o, oob_m);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    int          r;

    reset_n_i  = 1'b0;
    req_v_i    = 1'b0;
    req_data_i = '0;
    rsp_rdy_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_rsp_v", rsp_v_o, 1'b0);
    check("rst_rsp_data", rsp_data_o, 128'h0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_rdy", req_rdy_o, 1'b1);
    check("rst_oob", oob_err_o, 1'b0);
    check("rst_load_count", load_count_o, 32'h0);
    check("rst_store_count", store_count_o, 32'h0);

    // Basic store then load with full metadata.
    do_store(32'd5, 32'hA5A5_1234, 4'hF);
    do_load(32'd5, 11'h3C, 8'd2, 8'd3, 0);

    // Partial byte mask merges over existing data.
    do_store(32'd7, 32'h1111_1111, 4'hF);
    do_store(32'd7, 32'hFFFF_FFFF, 4'b0101);
    do_load(32'd7, 11'($urandom), 8'($urandom), 8'($urandom), 1);

    // Back-to-back stores with valid held high.
    r = int'(rsp_seen);
    for (int i = 0; i < 4; i++) begin
      data       = $urandom;
      req_v_i    = 1'b1;
      req_data_i = mk_req(32'(8 + i), 8'hA0, 8'h0F, data, 8'h0, 8'h0);
      check("burst_rdy", req_rdy_o, 1'b1);
      @(negedge clk_i);
      model_store(32'(8 + i), data, 4'hF);
    end
    req_v_i = 1'b0;
    check("burst_store_count", store_count_o, stores_m);
    check("burst_no_rsp", rsp_seen, 32'(r));

    // Zero mask: counted, nothing written.
    do_store(32'd5, 32'hDEAD_BEEF, 4'h0);
    check("zero_mask_count", store_count_o, stores_m);
    do_load(32'd5, 11'h001, 8'd0, 8'd0, 0);

    // Populate the random-traffic pool: words 0..15 and the last word.
    for (int a = 0; a < 16; a++) do_store(32'(a), $urandom, 4'hF);
    do_store(MEM_ELS - 1, $urandom, 4'hF);

    // Long back-pressure on the response.
    do_load(32'd3, 11'h7FF, 8'hFF, 8'h80, 10);

    // Out-of-range load and store.
    do_load(MEM_ELS, 11'h155, 8'd4, 8'd6, 2);
    do_store(32'hFFFF_FFFF, $urandom, 4'hF);
    check("oob_sticky", oob_err_o, 1'b1);
    do_load(MEM_ELS - 1, 11'h002, 8'd1, 8'd1, 0);
    do_load(32'd5, 11'h003, 8'd1, 8'd1, 0);

    // Random traffic over the pool plus occasional out-of-range addresses.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 16);
      addr = (r == 16) ? MEM_ELS - 1 : 32'(r);
      if ($urandom_range(0, 9) == 0) addr = MEM_ELS + $urandom_range(0, 100000);
      if ($urandom_range(0, 1) == 0)
        do_store(addr, $urandom, 4'($urandom));
      else
        do_load(addr, 11'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    check("rand_store_count", store_count_o, stores_m);
    check("rand_rsp_count", rsp_seen, rsp_m);

    // Asynchronous reset while a response is pending.
    send(mk_req(32'd9, 8'h00, 8'h00, 32'h0, 8'd1, 8'd1));
    @(negedge clk_i);
    check("pre_reset_rsp_v", rsp_v_o, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    check("async_rst_rsp_v", rsp_v_o, 1'b0);
    check("async_rst_load_count", load_count_o, 32'h0);
    check("async_rst_store_count", store_count_o, 32'h0);
    check("async_rst_oob", oob_err_o, 1'b0);
    check("async_rst_rdy", req_rdy_o, 1'b1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    loads_m  = 0;
    stores_m = 0;
    oob_m    = 1'b0;
    @(negedge clk_i);
    do_load(32'd9, 11'h0AA, 8'd7, 8'd8, 0);
    do_load(32'd7, 11'h0AB, 8'd7, 8'd8, 0);
    check("final_store_count", store_count_o, stores_m);
    check("final_rsp_count", rsp_seen, rsp_m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
